// File: rtl/haar_db_pkg.sv
// ============================================================================
// haar_db_pkg : shared constants, word layout and FSM encoding for the
//               Haar database stage streamer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package haar_db_pkg;

  localparam int DW            = 12;
  localparam int WORD_CNT_W    = 24;

  // Tree layout: 3 rectangles x 5 fields, then threshold, left, right.
  localparam int NUM_RECTS       = 3;
  localparam int RECT_FIELDS     = 5;
  localparam int RECT_BASE_OFS   = 0;
  localparam int TREE_THRESH_OFS = RECT_BASE_OFS + NUM_RECTS * RECT_FIELDS;
  localparam int LEFT_OFS        = TREE_THRESH_OFS + 1;
  localparam int RIGHT_OFS       = LEFT_OFS + 1;

  localparam int WORDS_PER_TREE_DEF       = RIGHT_OFS + 1;
  localparam int TREES_PER_CLASSIFIER_DEF = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_THRESH = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

  typedef struct packed {
    logic [DW-1:0] idx_db;
    logic [DW-1:0] idx_tree;
    logic [DW-1:0] idx_cls;
    logic          end_tree;
    logic          end_single;
    logic          end_all;
    logic          end_db;
  } db_meta_t;

  typedef struct packed {
    logic [DW-1:0] data;
    db_meta_t      meta;
  } db_word_t;

endpackage

`default_nettype wire

// File: rtl/haar_db_skid.sv
// ============================================================================
// haar_db_skid : one-entry skid register holding a database word together
//                with its indices and end flags.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module haar_db_skid
  import haar_db_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     i_wr,
  input  db_word_t i_word,
  input  logic     i_rd,
  output logic     o_full,
  output db_word_t o_word
);

  logic     r_full;
  db_word_t r_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 1'b0;
      r_word <= '0;
    end else if (i_wr) begin
      r_full <= 1'b1;
      r_word <= i_word;
    end else if (i_rd) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_word = r_word;

endmodule

`default_nettype wire

// File: rtl/haar_database_streamer.sv
// ============================================================================
// haar_database_streamer : reads one cascade stage from the Haar database ROM
//                          and streams it word by word with indices and flags.
// Revision               : 1.0
// ============================================================================
`default_nettype none

module haar_database_streamer
  import haar_db_pkg::*;
#(
  parameter int DATA_WIDTH_12        = DW,
  parameter int ADDR_WIDTH           = 16,
  parameter int WORDS_PER_TREE       = WORDS_PER_TREE_DEF,
  parameter int TREES_PER_CLASSIFIER = TREES_PER_CLASSIFIER_DEF
)(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [DATA_WIDTH_12-1:0] num_classifier,
  input  logic                     hold,
  output logic                     rom_rd,
  output logic [ADDR_WIDTH-1:0]    rom_addr,
  input  logic [DATA_WIDTH_12-1:0] rom_data,
  output logic [DATA_WIDTH_12-1:0] data,
  output logic                     valid,
  output logic [DATA_WIDTH_12-1:0] index_database,
  output logic [DATA_WIDTH_12-1:0] index_tree,
  output logic [DATA_WIDTH_12-1:0] index_classifier,
  output logic                     end_tree,
  output logic                     end_single_classifier,
  output logic                     end_all_classifier,
  output logic                     end_database,
  output logic                     busy
);

  localparam int WORDS_PER_CLASSIFIER = WORDS_PER_TREE * TREES_PER_CLASSIFIER;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [WORD_CNT_W-1:0] r_tree_words;
  logic [WORD_CNT_W-1:0] r_rd_cnt;
  logic [DW-1:0]         r_rd_db;
  logic [DW-1:0]         r_rd_tree;
  logic [DW-1:0]         r_rd_cls;
  logic                  r_pend;
  db_meta_t              r_pend_meta;
  logic                  r_out_valid;
  db_word_t              r_out;

  logic     w_issue;
  logic     w_load;
  logic     w_skid_wr;
  logic     w_skid_rd;
  logic     w_skid_full;
  logic     w_last_db;
  logic     w_last_tree;
  logic     w_last_word;
  db_meta_t w_issue_meta;
  db_word_t w_arrive_word;
  db_word_t w_skid_word;

  assign w_last_db   = (r_rd_db == DW'(WORDS_PER_TREE - 1));
  assign w_last_tree = (r_rd_tree == DW'(TREES_PER_CLASSIFIER - 1));
  assign w_last_word = (r_rd_cnt == r_tree_words - WORD_CNT_W'(1));

  // A read is only issued when its returning word is guaranteed a place.
  assign w_issue   = ((r_state == ST_FETCH) || (r_state == ST_THRESH)) && !w_skid_full && !hold;
  assign w_load    = !r_out_valid || !hold;
  assign w_skid_wr = r_pend && !w_load;
  assign w_skid_rd = w_load && w_skid_full;

  always_comb begin
    w_issue_meta = '0;
    if (r_state == ST_THRESH) begin
      w_issue_meta.end_db = 1'b1;
    end else begin
      w_issue_meta.idx_db     = r_rd_db;
      w_issue_meta.idx_tree   = r_rd_tree;
      w_issue_meta.idx_cls    = r_rd_cls;
      w_issue_meta.end_tree   = w_last_db;
      w_issue_meta.end_single = w_last_db && w_last_tree;
      w_issue_meta.end_all    = w_last_word;
    end
  end

  always_comb begin
    w_arrive_word      = '0;
    w_arrive_word.data = rom_data;
    w_arrive_word.meta = r_pend_meta;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_base       <= '0;
      r_tree_words <= '0;
      r_rd_cnt     <= '0;
      r_rd_db      <= '0;
      r_rd_tree    <= '0;
      r_rd_cls     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_base       <= base_addr;
            r_tree_words <= WORD_CNT_W'(num_classifier) * WORD_CNT_W'(WORDS_PER_CLASSIFIER);
            r_rd_cnt     <= '0;
            r_rd_db      <= '0;
            r_rd_tree    <= '0;
            r_rd_cls     <= '0;
            r_state      <= (num_classifier == '0) ? ST_THRESH : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_issue) begin
            r_rd_cnt <= r_rd_cnt + WORD_CNT_W'(1);
            if (w_last_db) begin
              r_rd_db <= '0;
              if (w_last_tree) begin
                r_rd_tree <= '0;
                r_rd_cls  <= r_rd_cls + DW'(1);
              end else begin
                r_rd_tree <= r_rd_tree + DW'(1);
              end
            end else begin
              r_rd_db <= r_rd_db + DW'(1);
            end
            if (w_last_word) r_state <= ST_THRESH;
          end
        end
        ST_THRESH: begin
          if (w_issue) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_out_valid && !hold && r_out.meta.end_db) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: the skid word always goes out before newer ROM data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend      <= 1'b0;
      r_pend_meta <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) r_pend_meta <= w_issue_meta;
      if (w_load) begin
        if (w_skid_full) begin
          r_out       <= w_skid_word;
          r_out_valid <= 1'b1;
        end else if (r_pend) begin
          r_out       <= w_arrive_word;
          r_out_valid <= 1'b1;
        end else begin
          r_out       <= '0;
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  haar_db_skid u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .i_wr    (w_skid_wr),
    .i_word  (w_arrive_word),
    .i_rd    (w_skid_rd),
    .o_full  (w_skid_full),
    .o_word  (w_skid_word)
  );

  assign rom_rd                = w_issue;
  assign rom_addr              = w_issue ? (r_base + r_rd_cnt[ADDR_WIDTH-1:0]) : '0;
  assign data                  = r_out.data;
  assign valid                 = r_out_valid;
  assign index_database        = r_out.meta.idx_db;
  assign index_tree            = r_out.meta.idx_tree;
  assign index_classifier      = r_out.meta.idx_cls;
  assign end_tree              = r_out.meta.end_tree;
  assign end_single_classifier = r_out.meta.end_single;
  assign end_all_classifier    = r_out.meta.end_all;
  assign end_database          = r_out.meta.end_db;
  assign busy                  = (r_state != ST_IDLE);

endmodule

`default_nettype wire
